// File: rtl/nonce_reporter_if.sv
// -----------------------------------------------------------------------------
// nonce_reporter_if
//  Bundles the nonce-extractor beat inputs, the host-link byte stream and the
//  status outputs of nonce_reporter.
//  slave  : the reporter side (consumes beats and tx_ready_i, drives the stream)
//  master : the environment side (extractor + host link + status observer)
//  Signals:
//   valid_i, newblock_i, success_i, nonce_i[31:0]  beat from the nonce extractor
//   tx_ready_i                                     sink accepts tx_data_o
//   tx_data_o[7:0], tx_valid_o                     frame byte stream
//   found_o, overflow_o, block_id_o[7:0]           status
// -----------------------------------------------------------------------------
interface nonce_reporter_if;
    logic        valid_i;
    logic        newblock_i;
    logic        success_i;
    logic [31:0] nonce_i;
    logic        tx_ready_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        found_o;
    logic        overflow_o;
    logic [7:0]  block_id_o;

    modport slave (
        input  valid_i, newblock_i, success_i, nonce_i, tx_ready_i,
        output tx_data_o, tx_valid_o, found_o, overflow_o, block_id_o
    );

    modport master (
        output valid_i, newblock_i, success_i, nonce_i, tx_ready_i,
        input  tx_data_o, tx_valid_o, found_o, overflow_o, block_id_o
    );
endinterface

// File: rtl/nonce_reporter.sv
// -----------------------------------------------------------------------------
// nonce_reporter
//  Captures winning nonces from the nonce extractor, tags each with an 8-bit
//  block sequence id, queues them in a small FIFO and serialises each one as a
//  7-byte frame on a valid/ready byte stream:
//    HEADER, block_id, nonce[31:24], nonce[23:16], nonce[15:8], nonce[7:0], chk
//  where chk is the XOR of bytes 1..5.
//  Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset
//   bus  nonce_reporter_if.slave (beat inputs, byte stream, status)
//  Parameters:
//   FIFO_DEPTH  queued {block_id,nonce} entries (power of two, >= 2)
//   FIRST_ONLY  1: report only the first success of each block
//   HEADER      frame sync byte
// -----------------------------------------------------------------------------
module nonce_reporter #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          FIRST_ONLY = 1'b1,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    nonce_reporter_if.slave  bus
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // ---------------------------------------------------------------- status
    logic [7:0] block_id_q, block_id_d;
    logic       found_q, found_d;
    logic       overflow_q, overflow_d;

    // ---------------------------------------------------------------- FIFO
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [39:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        fifo_empty, fifo_full;
    logic [39:0] fifo_head;

    // ---------------------------------------------------------------- framer
    logic [0:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [39:0] frame_q, frame_d;     // {block_id, nonce}
    logic [7:0]  chk;
    logic [7:0]  tx_byte;

    logic capture, push, pop, drop, last_hs;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_head  = mem_q[rd_ptr_q[AW-1:0]];

    // Success on a newblock beat carries a stale nonce and is never captured.
    assign capture = bus.valid_i && !bus.newblock_i && bus.success_i &&
                     (!FIRST_ONLY || !found_q);

    assign last_hs = (state_q == ST_SEND) && bus.tx_ready_i && (idx_q == 3'd6);
    assign pop     = !fifo_empty && ((state_q == ST_IDLE) || last_hs);

    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push = capture && (!fifo_full || pop);
    assign drop = capture && fifo_full && !pop;

    always_comb begin
        block_id_d = block_id_q;
        found_d    = found_q;
        overflow_d = overflow_q;
        if (bus.valid_i && bus.newblock_i) begin
            block_id_d = block_id_q + 8'd1;
            found_d    = 1'b0;
        end else if (capture) begin
            // Found is set even when the entry is dropped, so a full FIFO
            // does not turn into repeated overflow attempts for one block.
            found_d = 1'b1;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    frame_d = fifo_head;
                    idx_d   = 3'd0;
                    state_d = ST_SEND;
                end
            end
            default: begin
                if (bus.tx_ready_i) begin
                    if (idx_q == 3'd6) begin
                        idx_d = 3'd0;
                        // Chain straight into the next frame with no idle cycle.
                        if (!fifo_empty) frame_d = fifo_head;
                        else             state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
        endcase
    end

    assign chk = frame_q[39:32] ^ frame_q[31:24] ^ frame_q[23:16] ^
                 frame_q[15:8]  ^ frame_q[7:0];

    always_comb begin
        tx_byte = HEADER;
        case (idx_q)
            3'd0:    tx_byte = HEADER;
            3'd1:    tx_byte = frame_q[39:32];
            3'd2:    tx_byte = frame_q[31:24];
            3'd3:    tx_byte = frame_q[23:16];
            3'd4:    tx_byte = frame_q[15:8];
            3'd5:    tx_byte = frame_q[7:0];
            default: tx_byte = chk;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            block_id_q <= 8'd0;
            found_q    <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= ST_IDLE;
            idx_q      <= 3'd0;
            frame_q    <= 40'd0;
        end else begin
            block_id_q <= block_id_d;
            found_q    <= found_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            frame_q    <= frame_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {block_id_q, bus.nonce_i};
    end

    // Outputs come straight from reset flops so a reset drops tx_valid_o at once.
    assign bus.tx_valid_o = (state_q == ST_SEND);
    assign bus.tx_data_o  = (state_q == ST_SEND) ? tx_byte : 8'd0;
    assign bus.found_o    = found_q;
    assign bus.overflow_o = overflow_q;
    assign bus.block_id_o = block_id_q;

endmodule
